// File: rtl/fp_mac_pkg.sv
// Shared definitions for the floating-point MAC pipeline stages.
package fp_mac_pkg;

  localparam int unsigned FP_EXP_W   = 8;
  localparam int unsigned FP_MAN_W   = 24;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] pack(input logic       sign,
                                       input logic [7:0]  exp,
                                       input logic [22:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/step4_normalize.sv
// Pipeline stage 4: iterative left-shift normalization of the adder result
// and packing into an FP32 word, with valid/ready on both sides.
module step4_normalize
  import fp_mac_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_adder_out,
  input  logic        in_ov_sign,
  input  logic        in_adder_out_sign,
  input  logic [7:0]  in_current_ex,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow
);

  state_t      state_q, state_d;
  logic [23:0] m_q, m_d;
  logic [8:0]  e_q, e_d;
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        to_done;
  logic        force_ff;
  logic        sat;
  logic        sign_d;
  logic [8:0]  e0;
  logic [8:0]  e_carry;
  logic [7:0]  exp_f;
  logic [22:0] frac_f;

  // Exponent 0 shares the scale of exponent 1 (denormal handling).
  assign e0      = (in_current_ex == 8'h00) ? 9'd1 : {1'b0, in_current_ex};
  assign e_carry = e0 + 9'd1;

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    to_done  = 1'b0;
    force_ff = 1'b0;
    sat      = 1'b0;
    sign_d   = res_q[31];

    case (state_q)
      IDLE: begin
        sign_d = in_adder_out_sign;
        if (in_valid) begin
          if (in_current_ex == FP_EXP_MAX) begin
            m_d      = in_adder_out;
            e_d      = 9'd255;
            force_ff = 1'b1;
            to_done  = 1'b1;
          end else begin
            if (in_ov_sign) begin
              m_d = {1'b1, in_adder_out[23:1]};
              e_d = e_carry;
            end else begin
              m_d = in_adder_out;
              e_d = e0;
            end
            if (in_ov_sign && (e_carry == 9'd255)) begin
              m_d      = '0;
              e_d      = 9'd255;
              force_ff = 1'b1;
              sat      = 1'b1;
              to_done  = 1'b1;
            end else if ((m_d == '0) || m_d[23] || (e_d == 9'd1)) begin
              to_done = 1'b1;
            end else begin
              state_d = NORM;
            end
          end
        end
      end
      NORM: begin
        m_d = {m_q[22:0], 1'b0};
        e_d = e_q - 9'd1;
        if (m_d[23] || (e_d == 9'd1)) to_done = 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    exp_f  = force_ff ? FP_EXP_MAX : (m_d[23] ? e_d[7:0] : 8'h00);
    frac_f = m_d[22:0];
    if (to_done) begin
      state_d = DONE;
      res_d   = pack(sign_d, exp_f, frac_f);
      ovf_d   = sat;
      unf_d   = !force_ff && (exp_f == 8'h00) && (frac_f != '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_step4_normalize.sv
// Directed self-checking bench for step4_normalize.
module tb_step4_normalize;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_adder_out = '0;
  logic        in_ov_sign = 1'b0;
  logic        in_adder_out_sign = 1'b0;
  logic [7:0]  in_current_ex = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  step4_normalize dut (
    .clock             (clock),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_adder_out      (in_adder_out),
    .in_ov_sign        (in_ov_sign),
    .in_adder_out_sign (in_adder_out_sign),
    .in_current_ex     (in_current_ex),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_overflow      (out_overflow),
    .out_underflow     (out_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive_accept(input logic [23:0] m, input logic ov, input logic s,
                              input logic [7:0] ex);
    @(negedge clock);
    in_adder_out      = m;
    in_ov_sign        = ov;
    in_adder_out_sign = s;
    in_current_ex     = ex;
    in_valid          = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [23:0] m, input logic ov,
                       input logic s, input logic [7:0] ex, input logic [31:0] exp_res,
                       input logic exp_ovf, input logic exp_unf, input int exp_n);
    int n;
    drive_accept(m, ov, s, ex);
    wait_valid(n);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, exp_ovf});
    chk({tag, "_unf"}, {31'd0, out_underflow}, {31'd0, exp_unf});
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk({tag, "_exit_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_exit_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", out_result, 32'd0);
    chk("rst_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_op("basic",   24'h800000, 1'b0, 1'b0, 8'h7F, 32'h3F800000, 1'b0, 1'b0, 0);
    do_op("carry",   24'h000000, 1'b1, 1'b0, 8'h7F, 32'h40000000, 1'b0, 1'b0, 0);
    do_op("fullsh",  24'h000001, 1'b0, 1'b0, 8'h7F, 32'h34000000, 1'b0, 1'b0, 23);
    do_op("denorm",  24'h400000, 1'b0, 1'b0, 8'h01, 32'h00400000, 1'b0, 1'b1, 0);
    do_op("negzero", 24'h000000, 1'b0, 1'b1, 8'h00, 32'h80000000, 1'b0, 1'b0, 0);
    do_op("ex0",     24'h200000, 1'b0, 1'b0, 8'h00, 32'h00200000, 1'b0, 1'b1, 0);
    do_op("shdenorm",24'h000100, 1'b0, 1'b0, 8'h05, 32'h00001000, 1'b0, 1'b1, 4);
    do_op("ovf",     24'h123456, 1'b1, 1'b1, 8'hFE, 32'hFF800000, 1'b1, 1'b0, 0);
    do_op("carry2",  24'hC00001, 1'b1, 1'b0, 8'h80, 32'h40E00000, 1'b0, 1'b0, 0);
    do_op("inf",     24'h800000, 1'b0, 1'b1, 8'hFF, 32'hFF800000, 1'b0, 1'b0, 0);

    // Backpressure: result held and new inputs ignored while DONE stalls.
    drive_accept(24'h800000, 1'b0, 1'b0, 8'h7F);
    wait_valid(n);
    chk("bp_lat", n, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      in_adder_out  = 24'h000001;
      in_current_ex = 8'h10;
      in_valid      = i[0];
      @(posedge clock);
      #1;
      chk("bp_res", out_result, 32'h3F800000);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("bp_exit_rdy", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of the shift loop.
    drive_accept(24'h000001, 1'b0, 1'b1, 8'h7F);
    repeat (5) @(posedge clock);
    #1;
    chk("mid_rdy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("ar_rdy", {31'd0, in_ready}, 32'd1);
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_res", out_result, 32'd0);
    chk("ar_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    do_op("post_rst", 24'h000000, 1'b1, 1'b0, 8'h7F, 32'h40000000, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step4_normalize.md
# step4_normalize

Fourth stage of the floating-point MAC pipeline. It consumes the registered adder result (24-bit magnitude, carry-out flag, sign, working exponent) and produces a packed IEEE-754 single-precision word. Normalization is iterative: one left shift per cycle. The stage has a valid/ready handshake on both sides.

## Interface
- No parameters; all widths are fixed to FP32.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream stage-3 outputs are valid.
- `in_ready` out 1: stage can accept; equals (state==IDLE).
- `in_adder_out` in 24: magnitude including the hidden bit (bit 23).
- `in_ov_sign` in 1: adder carry-out; value is {1, in_adder_out}.
- `in_adder_out_sign` in 1: result sign.
- `in_current_ex` in 8: biased exponent before normalization.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: downstream accepts the result.
- `out_result` out 32: packed FP32 {sign, exp[7:0], frac[22:0]}.
- `out_overflow` out 1: result saturated to infinity.
- `out_underflow` out 1: result is denormal (exp field 0, fraction nonzero).

## Operation
- States:
  - IDLE: in_ready=1.
  - NORM: left-shift loop.
  - DONE: out_valid=1.
- Accept on the rising edge with in_valid && in_ready. Latch internal registers M[23:0], E[8:0] and S as follows:
  - in_current_ex==8'hFF (Inf/NaN): M=in_adder_out and E=255. Go to DONE with no shifting and no flags.
  - Otherwise, set E0 = max(in_current_ex, 1). This gives exp 0 the same scale as exp 1.
  - If in_ov_sign=1: M = {1, in_adder_out[23:1]} (truncate the dropped LSB) and E = E0+1.
  - If in_ov_sign=0: M = in_adder_out and E = E0.
  - If E reaches 255 from the carry path: force Inf (M=0, E=255, out_overflow=1) and go to DONE.
  - Else if M==0: go to DONE (signed zero, sign = in_adder_out_sign).
  - Else if M[23]==1 or E==1: go to DONE.
  - Else: go to NORM.
- NORM, each cycle:
  - M <= M<<1 and E <= E-1.
  - Go to DONE when the new M[23]==1 or the new E==1. Both are tested on the post-shift values.
  - Maximum of 23 shifts.
- Packing in DONE: exp field = M[23] ? E[7:0] : 8'h00; frac = M[22:0]. out_underflow = (exp field 0 && frac != 0).
- Rounding is truncation only; no guard or sticky bits exist upstream.
- DONE exits to IDLE on out_valid && out_ready. No new accept occurs in the same cycle; in_ready rises the cycle after.
- The exponent never wraps. E is 9 bits internally, left shifts stop at E==1, and the carry path saturates at 255.

## Timing
- Reset (async, active-high) values:
  - state=IDLE, out_result=0, out_valid=0, out_overflow=0, out_underflow=0.
  - M=0, E=0.
  - in_ready=1 while and after reset.
- Latency: accept at edge k. With n shifts, out_valid is high from cycle k+1+n; n is 0..23.
- Throughput: at most one result per (2+n) cycles; no overlap.
- out_result and the flags are registered. They are stable for the whole time out_valid=1, regardless of out_ready.
- in_valid while in_ready=0 is ignored. Upstream must hold its data.
- Reset asserted in NORM or DONE aborts immediately with no output. The next accept may occur on the first edge after reset deasserts.

## Structure
- Shared package `fp_mac_pkg`:
  - constants FP_EXP_W=8, FP_MAN_W=24, FP_EXP_MAX=8'hFF.
  - state typedef (IDLE/NORM/DONE).
  - pack function {sign, exp, frac}.
- Single module; no sub-module. The shifter is one register with a shift-by-one input mux, not a separate block.

## Test plan
- Basic normal value: in_adder_out=24'h800000, ov=0, ex=8'h7F, sign=0. Expect out_result=32'h3F800000 at k+1, no flags.
- Carry path: ov=1, in_adder_out=24'h000000, ex=8'h7F (1.0+1.0). Expect 32'h40000000 at k+1.
- Full-length shift: in_adder_out=24'h000001, ov=0, ex=8'h7F. Expect 23 NORM cycles, then 32'h34000000 with out_valid at k+24.
- Denormal result: in_adder_out=24'h400000, ex=8'h01. Expect 32'h00400000 at k+1, out_underflow=1. Also ex=8'h00 with 24'h000000 and sign=1: expect 32'h80000000, no flags.
- Overflow: ov=1, ex=8'hFE, sign=1. Expect 32'hFF800000 and out_overflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE. Expect out_result stable and in_ready=0 throughout, with in_valid pulses ignored.
  - Assert reset during NORM. Expect all outputs zero and in_ready=1.
  - After release, a new accept completes normally.
